calc_display_rx: RTL and testbench
==================================

# calc_display_rx

Display receiver for the calculator core. It consumes the core's digit-serial display stream (`status`, `data`, `pos`) and assembles complete 8-digit frames. It commits each complete frame to a display buffer and time-multiplexes that buffer onto eight active-low seven-segment displays. It sits between the calculator core and the board pins.

## Interface
- `NUM_DIGITS`, 8: digits per frame and display count; fixed at 8, parameter kept for elaboration checks only.
- `REFRESH_DIV`, 50000: clock cycles each digit stays lit; minimum 1; bench uses 4.
- `clock`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `status` in  2  core status: 00 error, 01 busy, 10 ready, 11 reserved (treated as ready).
- `data`   in  4  BCD digit for position `pos`.
- `pos`    in  4  digit index 0..7, 0 = least significant.
- `an`     out 8  anode enables, active-low, one-hot-zero.
- `seg`    out 7  segments `{g,f,e,d,c,b,a}`, active-low.
- `frame_done` out 1  one-cycle pulse after a frame commit.
- `err`    out 1  sticky error flag.

## Operation
- **Beat:** a cycle with `status == 01` is a beat. `(pos, data)` is sampled on every beat. No sampling occurs when `status` is 10 or 11.
- **Frame assembly:** an internal counter `expect` (0..7) tracks the next position.
  - Beat with `pos == expect`: `shadow[pos] <= data`, then `expect++`.
  - Beat with `pos == 0`: always restarts the frame. `shadow[0]` is written and `expect <= 1`.
  - Any other beat, including `pos > 7`: aborts the frame. `expect <= 0`, nothing is written, and the buffer is unchanged.
- **Commit:** a beat with `pos == 7 == expect` commits the frame.
  - `buffer <= {data, shadow[6:0]}` on the same edge.
  - `expect <= 0`.
  - `frame_done` is high for exactly the next cycle.
- **Error:**
  - Any cycle with `status == 00` sets `err`. It clears only on `reset`.
  - While `err` is set, beats are ignored: no shadow writes and no commits.
  - The display shows error pattern: digit 2 = "E" (06), digits 1 and 0 = "r" (2F), others blank (7F).
- **Decode (hex, active-low):**
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Values A–F decode to blank (7F).
- **Leading-zero blanking:** digit i (i ≥ 1) is blank when `buffer[i..7]` are all 0. Digit 0 is always shown.
- **Scan:**
  - A divider counts 0..`REFRESH_DIV`-1. On wrap, the scan index advances 7→0 mod 8.
  - `an <= ~(1 << idx)` and `seg <= decode(idx)`, both registered every cycle.

## Timing
- **Reset values:** `an` = FF, `seg` = 7F, `frame_done` = 0, `err` = 0, buffer and shadow all 0, `expect` = 0, divider and scan index = 0.
- **First edge after reset release:** `an` = FE, `seg` = 40 (buffer holds zero).
- **Latencies:**
  - Commit to buffer: same edge as the pos-7 beat.
  - Buffer to `seg`: one cycle when that digit is selected.
  - `status` 00 to `err`: one edge. The error pattern is visible on `seg` from the following edge.
- **Simultaneous events:** if `status == 00` and a would-be commit fall on the same cycle, the error wins and there is no commit.
- **Reset mid-frame:** the partial frame is discarded. The buffer returns to 0.

## Structure
- **Package `calc_pkg`:**
  - status encodings `ST_ERR`, `ST_BUSY`, `ST_READY`
  - `NUM_DIGITS`
  - segment constants `SEG_BLANK`, `SEG_E`, `SEG_R`
  - the digit decode table
- **Sub-module `seg7_decode`:** combinational, 4-bit value in, 7-bit active-low segments out. Blank for values above 9.
- **Top level:** frame assembler, error latch, divider/scan counter, and output registers.

## Test plan
- **Reset:** assert `reset` low mid-run → `an` = FF, `seg` = 7F immediately. After release, the next edge gives `an` = FE, `seg` = 40.
- **Commit:** beats pos 0..7 with data 5,2,0,0,0,0,0,0 (`REFRESH_DIV` = 4) → `frame_done` is high one cycle after the pos-7 beat. Scan shows idx0 `seg` = 12, idx1 `seg` = 24, idx2..7 `seg` = 7F.
- **Abort:** beats pos 0,1,2,5 with data 9 → no `frame_done`, display unchanged. A following full frame of 3s commits and shows 33333333 (`seg` = 30 on all digits).
- **Error:** one cycle of `status` = 00, then `status` = 10 → `err` = 1. Scan shows idx2 = 06, idx1/0 = 2F, others 7F. A later full frame is ignored; `err` stays 1 until reset.
- **Non-BCD digit:** frame with `data` = B at pos 3 and 1s elsewhere → digit 3 `seg` = 7F, other digits `seg` = 79.
- **Reset mid-frame:** reset after the pos-3 beat → no commit, buffer 0. The next complete frame 7,0,...,0 shows idx0 = 78, idx1..7 blank.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the calculator display receiver: core status codes,
// frame geometry and the active-low seven-segment patterns.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_ERR   = 2'b00,
        ST_BUSY  = 2'b01,
        ST_READY = 2'b10,
        ST_RSVD  = 2'b11
    } status_e;

    localparam int NUM_DIGITS = 8;

    typedef logic [NUM_DIGITS-1:0][3:0] frame_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    // Index n holds the {g,f,e,d,c,b,a} active-low pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; values above 9 show
// as a blank digit.
module seg7_decode
    import calc_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (value_i < 4'd10) begin
            seg_o = SEG_DIGITS[value_i];
        end
    end

endmodule

// File: rtl/calc_display_rx.sv
// Display receiver: assembles digit-serial frames from the calculator core,
// commits them to a display buffer and scans that buffer onto eight digits.
module calc_display_rx
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       frame_done,
    output logic       err
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    if (NUM_DIGITS != calc_pkg::NUM_DIGITS) begin : g_bad_digits
        $error("calc_display_rx supports exactly 8 digits");
    end
    if (REFRESH_DIV < 1) begin : g_bad_div
        $error("calc_display_rx needs REFRESH_DIV >= 1");
    end

    logic [2:0]       expectPos_q, expectPos_d;
    logic [6:0][3:0]  shadow_q, shadow_d;
    frame_t           buffer_q, buffer_d;
    logic             frameDone_q, frameDone_d;
    logic             err_q, err_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       scanIdx_q, scanIdx_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic       beat;
    logic       divWrap;
    logic       upperZero;
    logic [6:0] decSeg;

    // Once the error latch is set the core stream is ignored entirely.
    assign beat = (status == ST_BUSY) && !err_q;

    always_comb begin
        expectPos_d = expectPos_q;
        shadow_d    = shadow_q;
        buffer_d    = buffer_q;
        frameDone_d = 1'b0;
        err_d       = err_q || (status == ST_ERR);
        if (beat) begin
            if (pos == 4'd7 && expectPos_q == 3'd7) begin
                buffer_d    = {data, shadow_q};
                expectPos_d = 3'd0;
                frameDone_d = 1'b1;
            end else if (pos == {1'b0, expectPos_q}) begin
                for (int i = 0; i < 7; i++) begin
                    if (pos == 4'(i)) begin
                        shadow_d[i] = data;
                    end
                end
                expectPos_d = 3'(expectPos_q + 3'd1);
            end else if (pos == 4'd0) begin
                shadow_d[0] = data;
                expectPos_d = 3'd1;
            end else begin
                expectPos_d = 3'd0;
            end
        end
    end

    assign divWrap = (div_q == DIV_W'(REFRESH_DIV - 1));

    always_comb begin
        div_d     = divWrap ? '0 : DIV_W'(div_q + 1'b1);
        scanIdx_d = divWrap ? 3'(scanIdx_q + 3'd1) : scanIdx_q;
        an_d      = ~(8'd1 << scanIdx_q);
    end

    // A digit is a leading zero when it and every more significant digit are 0.
    always_comb begin
        upperZero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(scanIdx_q) && buffer_q[i] != 4'd0) begin
                upperZero = 1'b0;
            end
        end
    end

    seg7_decode u_decode (
        .value_i (buffer_q[scanIdx_q]),
        .seg_o   (decSeg)
    );

    always_comb begin
        seg_d = SEG_BLANK;
        if (err_q) begin
            case (scanIdx_q)
                3'd2:       seg_d = SEG_E;
                3'd1, 3'd0: seg_d = SEG_R;
                default:    seg_d = SEG_BLANK;
            endcase
        end else if (scanIdx_q == 3'd0 || !upperZero) begin
            seg_d = decSeg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            expectPos_q <= 3'd0;
            shadow_q    <= '0;
            buffer_q    <= '0;
            frameDone_q <= 1'b0;
            err_q       <= 1'b0;
            div_q       <= '0;
            scanIdx_q   <= 3'd0;
            an_q        <= 8'hFF;
            seg_q       <= SEG_BLANK;
        end else begin
            expectPos_q <= expectPos_d;
            shadow_q    <= shadow_d;
            buffer_q    <= buffer_d;
            frameDone_q <= frameDone_d;
            err_q       <= err_d;
            div_q       <= div_d;
            scanIdx_q   <= scanIdx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frameDone_q;
    assign err        = err_q;

endmodule

// File: tb/tb_calc_display_rx.sv
// Scoreboard bench for calc_display_rx: the driver queues expected displays,
// a monitor pops them on frame_done (or at once) and scans the digits.
module tb_calc_display_rx;
    import calc_pkg::*;

    localparam int RDIV = 4;
    localparam logic [6:0] BL = 7'h7F;
    localparam int K_RESET   = 0;
    localparam int K_DISPLAY = 1;
    localparam int K_FRAME   = 2;

    typedef struct {
        int              kind;
        logic [7:0][6:0] segs;
        logic            expErr;
    } item_t;

    localparam logic [7:0][6:0] DISP_ZERO = {BL, BL, BL, BL, BL, BL, BL, 7'h40};
    localparam logic [7:0][6:0] DISP_52   = {BL, BL, BL, BL, BL, BL, 7'h24, 7'h12};
    localparam logic [7:0][6:0] DISP_3S   = {8{7'h30}};
    localparam logic [7:0][6:0] DISP_NBCD = {7'h79, 7'h79, 7'h79, 7'h79, 7'h7F, 7'h79, 7'h79, 7'h79};
    localparam logic [7:0][6:0] DISP_7    = {BL, BL, BL, BL, BL, BL, BL, 7'h78};
    localparam logic [7:0][6:0] DISP_ERR  = {BL, BL, BL, BL, BL, 7'h06, 7'h2F, 7'h2F};

    item_t sbQ[$];
    int    testsRun    = 0;
    int    testsFailed = 0;
    bit    busy        = 1'b0;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] status = 2'b10;
    logic [3:0] data   = 4'd0;
    logic [3:0] pos    = 4'd0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       frame_done;
    logic       err;

    always #5 clock = ~clock;

    calc_display_rx #(
        .NUM_DIGITS  (8),
        .REFRESH_DIV (RDIV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .status     (status),
        .data       (data),
        .pos        (pos),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done),
        .err        (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic pushItem(input int kind, input logic [7:0][6:0] segs, input logic expErr);
        item_t it;
        it.kind   = kind;
        it.segs   = segs;
        it.expErr = expErr;
        sbQ.push_back(it);
    endtask

    task automatic applyStimulus(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
        status = st;
        pos    = p;
        data   = d;
        @(posedge clock);
        #1;
    endtask

    task automatic sendFrame(input frame_t f);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(ST_BUSY, 4'(i), f[i]);
        end
        status = ST_READY;
        pos    = 4'd0;
        data   = 4'd0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((sbQ.size() != 0 || busy) && n < 600) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (sbQ.size() != 0 || busy) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sbQ.size());
        end
    endtask

    // Watch one full scan (plus margin) and compare every digit seen.
    task automatic scanCheck(input item_t it);
        bit         seen[8];
        bit         good[8];
        logic [6:0] lastSeg[8];
        logic [6:0] badSeg[8];
        logic [6:0] act;
        bit         anOk   = 1'b1;
        bit         fdHigh = 1'b0;
        int         k;
        for (int j = 0; j < 8; j++) begin
            seen[j]    = 1'b0;
            good[j]    = 1'b1;
            lastSeg[j] = 'x;
            badSeg[j]  = 'x;
        end
        repeat (40) begin
            @(negedge clock);
            k = -1;
            for (int j = 0; j < 8; j++) begin
                if (an === ~(8'd1 << j)) k = j;
            end
            if (k < 0) begin
                anOk = 1'b0;
            end else begin
                seen[k]    = 1'b1;
                lastSeg[k] = seg;
                if (seg !== it.segs[k]) begin
                    if (good[k]) badSeg[k] = seg;
                    good[k] = 1'b0;
                end
            end
            if (frame_done !== 1'b0) fdHigh = 1'b1;
        end
        for (int j = 0; j < 8; j++) begin
            act = !seen[j] ? 7'bx : (good[j] ? lastSeg[j] : badSeg[j]);
            checkOutput($sformatf("seg_idx%0d", j), {25'd0, act}, {25'd0, it.segs[j]});
        end
        checkOutput("an_one_hot", {31'd0, anOk}, 32'd1);
        checkOutput("frame_done_extra", {31'd0, fdHigh}, 32'd0);
        checkOutput("err_flag", {31'd0, err}, {31'd0, it.expErr});
    endtask

    task automatic checkReset();
        int n = 0;
        checkOutput("reset_an", {24'd0, an}, 32'hFF);
        checkOutput("reset_seg", {25'd0, seg}, 32'h7F);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        checkOutput("reset_frame_done", {31'd0, frame_done}, 32'd0);
        while (reset !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (reset !== 1'b1) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL reset_release: got reset low, required release within 50 cycles");
        end else begin
            @(posedge clock);
            #2;
            checkOutput("release_an", {24'd0, an}, 32'hFE);
            checkOutput("release_seg", {25'd0, seg}, 32'h40);
        end
    endtask

    initial begin : monitor
        item_t it;
        int    waitCnt = 0;
        forever begin
            @(negedge clock);
            if (sbQ.size() > 0 && sbQ[0].kind == K_RESET) begin
                busy = 1'b1;
                it   = sbQ.pop_front();
                checkReset();
                busy = 1'b0;
            end else if (frame_done === 1'b1) begin
                if (sbQ.size() > 0 && sbQ[0].kind == K_FRAME) begin
                    busy    = 1'b1;
                    it      = sbQ.pop_front();
                    waitCnt = 0;
                    testsRun++;
                    scanCheck(it);
                    busy = 1'b0;
                end else begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_frame_done: got 1, required 0");
                end
            end else if (sbQ.size() > 0 && sbQ[0].kind == K_DISPLAY) begin
                busy = 1'b1;
                it   = sbQ.pop_front();
                scanCheck(it);
                busy = 1'b0;
            end else if (sbQ.size() > 0 && sbQ[0].kind == K_FRAME) begin
                waitCnt++;
                if (waitCnt > 30) begin
                    it      = sbQ.pop_front();
                    waitCnt = 0;
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL frame_done_timeout: got 0, required 1 within 30 cycles");
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        // Power-on reset, then an empty buffer shows a single 0.
        #2 reset = 1'b0;
        pushItem(K_RESET, DISP_ZERO, 1'b0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        waitIdle();
        pushItem(K_DISPLAY, DISP_ZERO, 1'b0);
        waitIdle();

        pushItem(K_FRAME, DISP_52, 1'b0);
        sendFrame({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd5});
        waitIdle();

        // Out-of-order beat aborts; the old frame must stay on display.
        applyStimulus(ST_BUSY, 4'd0, 4'd9);
        applyStimulus(ST_BUSY, 4'd1, 4'd9);
        applyStimulus(ST_BUSY, 4'd2, 4'd9);
        applyStimulus(ST_BUSY, 4'd5, 4'd9);
        applyStimulus(ST_READY, 4'd0, 4'd0);
        pushItem(K_DISPLAY, DISP_52, 1'b0);
        waitIdle();

        // Full frame of 3s with a reserved-status cycle that must not be sampled.
        pushItem(K_FRAME, DISP_3S, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) applyStimulus(ST_RSVD, 4'd0, 4'd9);
            applyStimulus(ST_BUSY, 4'(i), 4'd3);
        end
        status = ST_READY;
        waitIdle();

        pushItem(K_FRAME, DISP_NBCD, 1'b0);
        sendFrame({4'd1, 4'd1, 4'd1, 4'd1, 4'hB, 4'd1, 4'd1, 4'd1});
        waitIdle();

        // Reset mid-frame discards the partial frame and clears the buffer.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ST_BUSY, 4'(i), 4'd6);
        end
        status = ST_READY;
        reset  = 1'b0;
        pushItem(K_RESET, DISP_ZERO, 1'b0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        waitIdle();
        pushItem(K_DISPLAY, DISP_ZERO, 1'b0);
        waitIdle();
        pushItem(K_FRAME, DISP_7, 1'b0);
        sendFrame({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7});
        waitIdle();

        // One error cycle latches err and switches to the Err pattern.
        applyStimulus(ST_ERR, 4'd0, 4'd0);
        status = ST_READY;
        pushItem(K_DISPLAY, DISP_ERR, 1'b1);
        waitIdle();
        sendFrame({8{4'd4}});
        pushItem(K_DISPLAY, DISP_ERR, 1'b1);
        waitIdle();

        reset = 1'b0;
        pushItem(K_RESET, DISP_ZERO, 1'b0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        waitIdle();
        pushItem(K_DISPLAY, DISP_ZERO, 1'b0);
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
